pid_ctrl_param: RTL and testbench
=================================

Name: pid_ctrl_param

Overview:
- Parametrised next-generation PID motor-assist controller for the eBike drive path.
- Converts a signed torque/cadence error into an unsigned drive magnitude for the motor-drive block.
- Generalises the fixed 13-bit/12-bit PID: configurable widths, derivative history depth and decimation rate.
- Adds an input valid/output valid handshake, a registered 2-stage pipeline, an integrator with hard clamps, and saturation flags.

Parameters:
- ERR_W, 13, error input width (signed two's complement).
- DRV_W, 12, drive magnitude width (unsigned).
- INTG_W, 18, integrator width; the MSB is overflow guard only.
- D_DEPTH, 3, number of decimated error samples held for the derivative.
- D_SAT_W, 9, signed width the derivative difference is clamped to.
- D_SHIFT, 1, left shift applied to the clamped derivative.
- FAST_SIM, 1, decimator width: 1 -> 15 bits, 0 -> 20 bits.

Ports:
- clk, input, 1, system clock.
- rst, input, 1, asynchronous active-high reset.
- err_vld, input, 1, error sample valid for this cycle.
- error, input, ERR_W, signed error sample.
- not_pedaling, input, 1, rider not pedaling; clears the integrator.
- drv_mag, output, DRV_W, registered clipped drive magnitude.
- drv_vld, output, 1, one-cycle pulse when drv_mag updates.
- sat_hi, output, 1, last output clipped to the maximum.
- sat_lo, output, 1, last output clipped to zero.

Behaviour:
- Reset (async, active-high): decimator, integrator, history and both pipeline stages clear to 0. drv_mag=0, drv_vld=0, sat_hi=0, sat_lo=0.
- Decimator: free-running counter, DEC_W = FAST_SIM ? 15 : 20. decim_full = counter all-ones; the counter wraps to 0 on the next clk.
- Integrator and history update only on (err_vld && decim_full).
- Integrator update:
  - next = intg + sext(error).
  - next < 0 -> 0.
  - next > 2^(INTG_W-1)-1 -> 2^(INTG_W-1)-1 (17'h1FFFF at defaults).
  - not_pedaling=1 forces intg=0 every cycle and overrides any update in the same cycle.
- History: shift register hist[0..D_DEPTH-1]. On update, hist[0]<=error and hist[k]<=hist[k-1].
- Derivative: d_raw = sext(error) - sext(hist[D_DEPTH-1]), clamped to the signed D_SAT_W range. d_term = d_clamped <<< D_SHIFT. It is combinational on every err_vld, not only on decim_full.
- P term: sext(error) to ERR_W+1 bits.
- I term: zero-extended intg[INTG_W-2 -: DRV_W]. The value used is the pre-update integrator, i.e. the register value in the err_vld cycle.
- Sum: signed, width DRV_W+3, all terms sign-extended before adding.
- Pipeline: stage 1 registers P/I/D on err_vld. Stage 2 registers the sum and the clip.
  - Latency: drv_vld asserts exactly 2 clks after err_vld.
  - Back-to-back err_vld is accepted every cycle; there is no stall.
- Clip:
  - sum < 0 -> drv_mag=0, sat_lo=1.
  - sum > 2^DRV_W-1 -> all ones, sat_hi=1.
  - Otherwise pass through, both flags 0.
  - Flags update with drv_mag.
- Hold: with no valid output, drv_mag and the flags hold and drv_vld=0.
- Reset mid-pipeline: in-flight samples are discarded and no drv_vld is produced.

Optional Feature:
- Macro: PID_DEADBAND_EN.
- Defined: an error with |error| <= 4 is treated as 0 for P, D, integrator and history. An error of exactly ±4 becomes 0.
- Undefined: error is used unmodified.

Decomposition:
- Shared package pid_pkg:
  - clamp/saturate function, parameterised by width via localparams.
  - default width localparams.
  - deadband threshold constant PID_DBAND = 4.
- One natural sub-module: pid_decimator, holding the counter and the decim_full output.

Test Plan:
- Reset held 3 clks, then released with err_vld=0 -> drv_mag=0, drv_vld=0, sat_hi=0, sat_lo=0.
- error=+100 held, err_vld=1 continuously, FAST_SIM=1 -> integrator +100 per decimator wrap. drv_vld is high every cycle after 2-clk latency, and drv_mag rises monotonically.
- error=+4095 sustained -> integrator clamps at 17'h1FFFF and never wraps. Output clips to 12'hFFF with sat_hi=1.
- error=-4096 with intg=0 -> intg stays 0, drv_mag=0, sat_lo=1.
- not_pedaling=1 asserted in the same cycle as decim_full with error=+500 -> intg=0 the next cycle. On release, the next update gives intg=500.
- Step error 0 -> +300 (D_DEPTH=3), checked on the next 3 decimated samples -> d_raw=300 clamps to 255, d_term=510. d_term returns to 0 once hist[2]=300.
- Deadband build with error=+3 -> identical to error=0. Non-deadband build with error=+3 -> P term 3.

Source files
------------

// File: rtl/pid_pkg.sv
// pid_pkg: default widths, deadband threshold and saturation helpers for the PID controller.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package pid_pkg;

   localparam int PID_ERR_W   = 13;
   localparam int PID_DRV_W   = 12;
   localparam int PID_INTG_W  = 18;
   localparam int PID_D_DEPTH = 3;
   localparam int PID_D_SAT_W = 9;
   localparam int PID_D_SHIFT = 1;
   localparam int PID_DBAND   = 4;

   // clamp v into the closed range [lo, hi]
   function automatic int clamp_range(input int v, input int lo, input int hi);
      int r;
      r = v;
      if (v < lo) begin
         r = lo;
      end else if (v > hi) begin
         r = hi;
      end
      return r;
   endfunction

   // saturate v to the range representable by a w-bit two's complement value
   function automatic int sat_signed(input int v, input int w);
      return clamp_range(v, -(1 <<< (w - 1)), (1 <<< (w - 1)) - 1);
   endfunction

endpackage

// File: rtl/pid_decimator.sv
// pid_decimator: free-running wrap counter; o_decim_full marks the all-ones count.
// Latency: o_decim_full is combinational from the counter register.
// Backpressure: none, the counter never stalls.
module pid_decimator #(
   parameter int DEC_W = 15
)(
   input  logic i_clk,
   input  logic i_rst,
   output logic o_decim_full
);

   logic [DEC_W-1:0] r_cnt;

   // count every clock, wrapping from all-ones back to zero
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + DEC_W'(1);
      end
   end

   assign o_decim_full = &r_cnt;

endmodule

// File: rtl/pid_ctrl_param.sv
// pid_ctrl_param: PID motor assist, signed error in, clipped unsigned drive magnitude out.
// Latency: drv_vld pulses exactly 2 clk after err_vld; optional deadband via PID_DEADBAND_EN.
// Backpressure: none, a new sample is accepted every cycle with no stall.
module pid_ctrl_param
   import pid_pkg::*;
#(
   parameter int ERR_W    = PID_ERR_W,
   parameter int DRV_W    = PID_DRV_W,
   parameter int INTG_W   = PID_INTG_W,
   parameter int D_DEPTH  = PID_D_DEPTH,
   parameter int D_SAT_W  = PID_D_SAT_W,
   parameter int D_SHIFT  = PID_D_SHIFT,
   parameter int FAST_SIM = 1
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             err_vld,
   input  logic [ERR_W-1:0] error,
   input  logic             not_pedaling,
   output logic [DRV_W-1:0] drv_mag,
   output logic             drv_vld,
   output logic             sat_hi,
   output logic             sat_lo
);

   localparam int DEC_W    = (FAST_SIM != 0) ? 15 : 20;
   localparam int P_W      = ERR_W + 1;
   localparam int D_W      = D_SAT_W + D_SHIFT;
   localparam int SUM_W    = DRV_W + 3;
   localparam int INTG_MAX = (1 << (INTG_W - 1)) - 1;

   logic                    w_decim_full;
   logic signed [ERR_W-1:0] w_err;
   logic                    w_upd;
   int                      w_intg_next;
   int                      w_d_raw;
   logic signed [D_W-1:0]   w_d_term;
   logic signed [SUM_W-1:0] w_sum;

   logic [INTG_W-1:0]       r_intg;
   logic signed [ERR_W-1:0] r_hist [D_DEPTH];
   logic                    r_s1_vld;
   logic signed [P_W-1:0]   r_p;
   logic [DRV_W-1:0]        r_i;
   logic signed [D_W-1:0]   r_d;
   logic [DRV_W-1:0]        r_drv_mag;
   logic                    r_drv_vld;
   logic                    r_sat_hi;
   logic                    r_sat_lo;

   pid_decimator #(
      .DEC_W (DEC_W)
   ) u_dec (
      .i_clk        (clk),
      .i_rst        (rst),
      .o_decim_full (w_decim_full)
   );

`ifdef PID_DEADBAND_EN
   // errors within the deadband are treated as exactly zero everywhere downstream
   assign w_err = ((int'($signed(error)) <= PID_DBAND) && (int'($signed(error)) >= -PID_DBAND))
                  ? '0 : $signed(error);
`else
   assign w_err = $signed(error);
`endif

   // integrator and history advance only on a valid sample in a decimation slot
   assign w_upd       = err_vld && w_decim_full;
   assign w_intg_next = clamp_range(int'(r_intg) + int'(w_err), 0, INTG_MAX);

   // derivative against the oldest held sample, evaluated on every valid sample
   assign w_d_raw  = int'(w_err) - int'(r_hist[D_DEPTH-1]);
   assign w_d_term = D_W'(sat_signed(w_d_raw, D_SAT_W) <<< D_SHIFT);

   // all three terms sign-extended; the I term is non-negative so it gets a zero sign bit
   assign w_sum = SUM_W'(r_p) + SUM_W'($signed({1'b0, r_i})) + SUM_W'(r_d);

   // integrator: clamped accumulate, cleared whenever the rider is not pedaling
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_intg <= '0;
      end else if (not_pedaling) begin
         r_intg <= '0;
      end else if (w_upd) begin
         r_intg <= INTG_W'(w_intg_next);
      end
   end

   // decimated error history used by the derivative
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < D_DEPTH; k++) begin
            r_hist[k] <= '0;
         end
      end else if (w_upd) begin
         r_hist[0] <= w_err;
         for (int k = 1; k < D_DEPTH; k++) begin
            r_hist[k] <= r_hist[k-1];
         end
      end
   end

   // stage 1: capture P, pre-update I and D for each valid sample
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s1_vld <= 1'b0;
         r_p      <= '0;
         r_i      <= '0;
         r_d      <= '0;
      end else begin
         r_s1_vld <= err_vld;
         if (err_vld) begin
            r_p <= P_W'(w_err);
            r_i <= r_intg[INTG_W-2 -: DRV_W];
            r_d <= w_d_term;
         end
      end
   end

   // stage 2: sum, clip to the unsigned drive range and flag saturation
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_drv_vld <= 1'b0;
         r_drv_mag <= '0;
         r_sat_hi  <= 1'b0;
         r_sat_lo  <= 1'b0;
      end else begin
         r_drv_vld <= r_s1_vld;
         if (r_s1_vld) begin
            if (w_sum[SUM_W-1]) begin
               r_drv_mag <= '0;
               r_sat_hi  <= 1'b0;
               r_sat_lo  <= 1'b1;
            end else if (|w_sum[SUM_W-2:DRV_W]) begin
               r_drv_mag <= '1;
               r_sat_hi  <= 1'b1;
               r_sat_lo  <= 1'b0;
            end else begin
               r_drv_mag <= w_sum[DRV_W-1:0];
               r_sat_hi  <= 1'b0;
               r_sat_lo  <= 1'b0;
            end
         end
      end
   end

   assign drv_mag = r_drv_mag;
   assign drv_vld = r_drv_vld;
   assign sat_hi  = r_sat_hi;
   assign sat_lo  = r_sat_lo;

endmodule

// File: tb/tb_pid_ctrl_param.sv
// tb_pid_ctrl_param: directed vectors for the PID controller at default parameters.
// Outputs are sampled 1 time unit after the rising edge.
// Expected values are hand-computed for the build with or without PID_DEADBAND_EN.
module tb_pid_ctrl_param;

   logic        clk          = 1'b0;
   logic        rst          = 1'b1;
   logic        err_vld      = 1'b0;
   logic        not_pedaling = 1'b0;
   logic [12:0] error        = '0;
   logic [11:0] drv_mag;
   logic        drv_vld;
   logic        sat_hi;
   logic        sat_lo;

   int n_pass  = 0;
   int n_total = 0;

   typedef struct {
      int e;
      bit np;
      int mag;
      bit hi;
      bit lo;
   } vec_t;

   vec_t tbl [10];

   pid_ctrl_param dut (
      .clk          (clk),
      .rst          (rst),
      .err_vld      (err_vld),
      .error        (error),
      .not_pedaling (not_pedaling),
      .drv_mag      (drv_mag),
      .drv_vld      (drv_vld),
      .sat_hi       (sat_hi),
      .sat_lo       (sat_lo)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [14:0] outs();
      return {drv_vld, sat_hi, sat_lo, drv_mag};
   endfunction

   task automatic chk(input string name, input logic [14:0] got, input logic [14:0] exp);
      n_total++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got vld=%0b hi=%0b lo=%0b mag=%0d, expected vld=%0b hi=%0b lo=%0b mag=%0d",
                  name, got[14], got[13], got[12], got[11:0], exp[14], exp[13], exp[12], exp[11:0]);
      end
   endtask

   task automatic chk_int(input string name, input int got, input int exp);
      n_total++;
      if (got == exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0d, expected %0d", name, got, exp);
      end
   endtask

   task automatic pulse_rst();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   // one valid sample, then check the result 2 clk later and that it holds afterwards
   task automatic run_vec(input string name, input int e, input bit np,
                          input int mag, input bit hi, input bit lo);
      error        = 13'(e);
      not_pedaling = np;
      err_vld      = 1'b1;
      tick();
      err_vld      = 1'b0;
      not_pedaling = 1'b0;
      tick();
      chk({name, "/out"}, outs(), {1'b1, hi, lo, 12'(mag)});
      tick();
      chk({name, "/hold"}, outs(), {1'b0, hi, lo, 12'(mag)});
   endtask

   initial begin
      int vld_cnt;
      int mono_bad;
      int prev;

      // decimation forced every cycle: step response, negative clip, not_pedaling
      tbl[0] = '{  300, 1'b0,  810, 1'b0, 1'b0};
      tbl[1] = '{  300, 1'b0,  819, 1'b0, 1'b0};
      tbl[2] = '{  300, 1'b0,  828, 1'b0, 1'b0};
      tbl[3] = '{  300, 1'b0,  328, 1'b0, 1'b0};
      tbl[4] = '{-4096, 1'b0,    0, 1'b0, 1'b1};
      tbl[5] = '{-4096, 1'b0,    0, 1'b0, 1'b1};
      tbl[6] = '{    0, 1'b0,    0, 1'b0, 1'b1};
      tbl[7] = '{  500, 1'b1, 1010, 1'b0, 1'b0};
      tbl[8] = '{  500, 1'b0, 1010, 1'b0, 1'b0};
      tbl[9] = '{    0, 1'b0,   15, 1'b0, 1'b0};

      // reset held 3 clk, then released with no valid input
      rst = 1'b1;
      repeat (3) tick();
      chk("reset_held", outs(), 15'd0);
      rst = 1'b0;
      tick();
      chk("reset_released", outs(), 15'd0);

      // natural decimation: error=+100 streamed across the first counter wrap
      pulse_rst();
      error    = 13'd100;
      err_vld  = 1'b1;
      vld_cnt  = 0;
      mono_bad = 0;
      prev     = 0;
      for (int k = 1; k <= 32770; k++) begin
         tick();
         if (k == 1) chk("latency_k1", outs(), 15'd0);
         if (k >= 2) begin
            if (drv_vld) vld_cnt++;
            if (int'(drv_mag) < prev) mono_bad++;
            prev = int'(drv_mag);
         end
         if (k == 32769) chk("pre_wrap", outs(), {1'b1, 2'b00, 12'd300});
         if (k == 32770) chk("post_wrap", outs(), {1'b1, 2'b00, 12'd303});
      end
      err_vld = 1'b0;
      chk_int("stream_vld_count", vld_cnt, 32769);
      chk_int("stream_monotonic_drops", mono_bad, 0);

      // from here on every cycle is a decimation slot
      force dut.w_decim_full = 1'b1;

      pulse_rst();
      for (int i = 0; i < 10; i++) begin
         run_vec($sformatf("vec%0d", i), tbl[i].e, tbl[i].np, tbl[i].mag, tbl[i].hi, tbl[i].lo);
      end

      // sustained +4095: integrator clamps at its maximum and output clips high
      pulse_rst();
      error   = 13'd4095;
      err_vld = 1'b1;
      repeat (40) tick();
      chk("intg_clamp_hi", outs(), {1'b1, 1'b1, 1'b0, 12'hFFF});
      error = 13'd0;
      tick();
      err_vld = 1'b0;
      tick();
      chk("intg_no_wrap", outs(), {1'b1, 2'b00, 12'd3583});

      // reset with a sample in flight: it must be dropped
      error   = 13'd100;
      err_vld = 1'b1;
      tick();
      err_vld = 1'b0;
      rst     = 1'b1;
      #1;
      chk("rst_mid", outs(), 15'd0);
      #1;
      rst = 1'b0;
      tick();
      chk("rst_discard1", outs(), 15'd0);
      tick();
      chk("rst_discard2", outs(), 15'd0);

      // small errors around the deadband edge
      pulse_rst();
`ifdef PID_DEADBAND_EN
      run_vec("dband_p3", 3, 1'b0,  0, 1'b0, 1'b0);
      run_vec("dband_p5", 5, 1'b0, 15, 1'b0, 1'b0);
      run_vec("dband_p4", 4, 1'b0,  0, 1'b0, 1'b0);
`else
      run_vec("dband_p3", 3, 1'b0,  9, 1'b0, 1'b0);
      run_vec("dband_p5", 5, 1'b0, 15, 1'b0, 1'b0);
      run_vec("dband_p4", 4, 1'b0, 12, 1'b0, 1'b0);
`endif

      release dut.w_decim_full;

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
